// File: rtl/toy_fetch_queue.sv
// Instruction-fetch front end: PC-driven 1-cycle memory requests feed a DEPTH-entry FIFO drained by decode.
// Fetch-to-head latency 2 cycles; issue stalls when queued plus in-flight words reach DEPTH; REDIR flushes all.
module toy_fetch_queue #(
  parameter int AW = 30,
  parameter int DW = 32,
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] RESET_ADDR = '0
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  output logic                       IREQ,
  output logic [AW-1:0]              IADDR,
  input  logic [DW-1:0]              INSTR,
  input  logic                       REDIR,
  input  logic [AW-1:0]              REDIR_ADDR,
  input  logic                       HALT,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [DW-1:0]              OUT_INSTR,
  output logic [AW-1:0]              OUT_ADDR,
  output logic [$clog2(DEPTH):0]     OCC
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] pc_q, pc_d;
  logic          infl_v_q, infl_v_d;
  logic [AW-1:0] infl_addr_q, infl_addr_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [DW-1:0] instr_mem_q [DEPTH];

  logic [CW:0] pending;
  logic        issue, head_v, push, pop;

  // Conservative credit: a pop in the same cycle does not free a slot for issue.
  assign pending = {1'b0, cnt_q} + (CW+1)'(infl_v_q);
  assign issue   = RSTN & ~REDIR & ~HALT & (pending < (CW+1)'(DEPTH));
  assign head_v  = (cnt_q != '0);
  assign push    = infl_v_q & ~REDIR;
  assign pop     = head_v & OUT_READY & ~REDIR;

  always_comb begin
    pc_d        = pc_q;
    infl_v_d    = infl_v_q;
    infl_addr_d = infl_addr_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    if (REDIR) begin
      pc_d     = REDIR_ADDR;
      infl_v_d = 1'b0;
      rd_d     = '0;
      wr_d     = '0;
      cnt_d    = '0;
    end else begin
      infl_v_d = issue;
      if (issue) begin
        infl_addr_d = pc_q;
        pc_d        = pc_q + AW'(1);
      end
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      pc_q        <= RESET_ADDR;
      infl_v_q    <= 1'b0;
      infl_addr_q <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
    end else begin
      pc_q        <= pc_d;
      infl_v_q    <= infl_v_d;
      infl_addr_q <= infl_addr_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTN && push) begin
      addr_mem_q[wr_q]  <= infl_addr_q;
      instr_mem_q[wr_q] <= INSTR;
    end
  end

  assign IREQ      = issue;
  assign IADDR     = RSTN ? pc_q : RESET_ADDR;
  assign OUT_VALID = RSTN & head_v;
  assign OUT_INSTR = OUT_VALID ? instr_mem_q[rd_q] : '0;
  assign OUT_ADDR  = OUT_VALID ? addr_mem_q[rd_q] : '0;
  assign OCC       = RSTN ? cnt_q : '0;

  a_no_push_when_full: assert property (@(posedge CLK) disable iff (!RSTN)
    !(push && cnt_q == CW'(DEPTH)));

endmodule

// File: tb/tb_toy_fetch_queue.sv
module tb_toy_fetch_queue;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] RA = 30'h10;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0, REDIR = 1'b0, HALT = 1'b0, OUT_READY = 1'b0;
  logic          IREQ, OUT_VALID;
  logic [AW-1:0] IADDR, OUT_ADDR;
  logic [AW-1:0] REDIR_ADDR = '0;
  logic [DW-1:0] INSTR = '0;
  logic [DW-1:0] OUT_INSTR;
  logic [2:0]    OCC;

  toy_fetch_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_ADDR(RA)) dut (
    .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
    .REDIR(REDIR), .REDIR_ADDR(REDIR_ADDR), .HALT(HALT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_INSTR(OUT_INSTR),
    .OUT_ADDR(OUT_ADDR), .OCC(OCC)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of fetched addresses, one pending request, fetch PC.
  logic [AW-1:0] mq[$];
  bit            m_infl = 1'b0;
  logic [AW-1:0] m_infl_addr = '0;
  logic [AW-1:0] m_pc = RA;
  logic [AW-1:0] last_iaddr = RA;

  logic          s_ireq, s_valid;
  logic [AW-1:0] s_iaddr, s_oaddr;
  logic [DW-1:0] s_oinstr;
  int            s_occ;

  typedef struct {
    bit            rstn;
    bit            ready;
    bit            e_ireq;
    logic [AW-1:0] e_iaddr;
    bit            e_valid;
    logic [AW-1:0] e_oaddr;
    int            e_occ;
  } vec_t;
  vec_t tbl[15];

  function automatic logic [DW-1:0] memw(input logic [AW-1:0] a);
    return 32'hA000_0000 | {2'b00, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rstn, input bit redir, input bit halt, input bit ready,
                      input logic [AW-1:0] raddr);
    bit            e_ireq, e_valid;
    logic [AW-1:0] e_oaddr;
    @(negedge CLK);
    RSTN = rstn; REDIR = redir; HALT = halt; OUT_READY = ready; REDIR_ADDR = raddr;
    INSTR = memw(last_iaddr);
    #1;
    e_ireq  = rstn && !redir && !halt && (mq.size() + int'(m_infl) < DEPTH);
    e_valid = rstn && mq.size() > 0;
    e_oaddr = e_valid ? mq[0] : '0;
    chk("m_ireq",   32'(IREQ),      32'(e_ireq));
    chk("m_iaddr",  32'(IADDR),     32'(rstn ? m_pc : RA));
    chk("m_valid",  32'(OUT_VALID), 32'(e_valid));
    chk("m_oaddr",  32'(OUT_ADDR),  32'(e_oaddr));
    chk("m_oinstr", OUT_INSTR,      e_valid ? memw(e_oaddr) : 32'h0);
    chk("m_occ",    32'(OCC),       rstn ? 32'(mq.size()) : 32'h0);
    s_ireq = IREQ; s_iaddr = IADDR; s_valid = OUT_VALID; s_oaddr = OUT_ADDR;
    s_oinstr = OUT_INSTR; s_occ = int'(OCC);
    last_iaddr = IADDR;
    @(posedge CLK);
    if (!rstn) begin
      mq.delete(); m_infl = 1'b0; m_pc = RA;
    end else if (redir) begin
      mq.delete(); m_infl = 1'b0; m_pc = raddr;
    end else begin
      if (e_valid && ready) void'(mq.pop_front());
      if (m_infl) mq.push_back(m_infl_addr);
      m_infl = e_ireq;
      if (e_ireq) begin
        m_infl_addr = m_pc;
        m_pc = m_pc + AW'(1);
      end
    end
  endtask

  initial begin
    logic [AW-1:0] resume;
    logic [AW-1:0] got[4];
    logic [AW-1:0] wrap_exp[4];
    int n;
    bit ok;

    tbl[0]  = '{0, 1, 0, 30'h10, 0, 30'h0,  0};
    tbl[1]  = '{0, 1, 0, 30'h10, 0, 30'h0,  0};
    tbl[2]  = '{0, 1, 0, 30'h10, 0, 30'h0,  0};
    tbl[3]  = '{1, 1, 1, 30'h10, 0, 30'h0,  0};
    tbl[4]  = '{1, 1, 1, 30'h11, 0, 30'h0,  0};
    tbl[5]  = '{1, 1, 1, 30'h12, 1, 30'h10, 1};
    tbl[6]  = '{1, 1, 1, 30'h13, 1, 30'h11, 1};
    tbl[7]  = '{1, 0, 1, 30'h14, 1, 30'h12, 1};
    tbl[8]  = '{1, 0, 1, 30'h15, 1, 30'h12, 2};
    tbl[9]  = '{1, 0, 0, 30'h16, 1, 30'h12, 3};
    tbl[10] = '{1, 0, 0, 30'h16, 1, 30'h12, 4};
    tbl[11] = '{1, 1, 0, 30'h16, 1, 30'h12, 4};
    tbl[12] = '{1, 1, 1, 30'h16, 1, 30'h13, 3};
    tbl[13] = '{1, 1, 1, 30'h17, 1, 30'h14, 2};
    tbl[14] = '{1, 1, 1, 30'h18, 1, 30'h15, 2};
    wrap_exp[0] = 30'h3FFF_FFFE; wrap_exp[1] = 30'h3FFF_FFFF;
    wrap_exp[2] = 30'h0;         wrap_exp[3] = 30'h1;

    // Reset, startup and backpressure against fixed expectations.
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rstn, 1'b0, 1'b0, tbl[i].ready, '0);
      chk("tbl_ireq",   32'(s_ireq),  32'(tbl[i].e_ireq));
      chk("tbl_iaddr",  32'(s_iaddr), 32'(tbl[i].e_iaddr));
      chk("tbl_valid",  32'(s_valid), 32'(tbl[i].e_valid));
      chk("tbl_oaddr",  32'(s_oaddr), 32'(tbl[i].e_oaddr));
      chk("tbl_oinstr", s_oinstr, tbl[i].e_valid ? memw(tbl[i].e_oaddr) : 32'h0);
      chk("tbl_occ",    32'(s_occ),   32'(tbl[i].e_occ));
    end

    // Redirect with three queued and one in flight.
    for (int i = 0; i < 8 && !(mq.size() == 3 && m_infl); i++) step(1, 0, 0, 0, '0);
    if (!(mq.size() == 3 && m_infl)) begin
      failures++; $display("FAIL redir_setup: timeout reaching occ=3 with request in flight");
    end
    step(1, 1, 0, 1, 30'h200);
    chk("redir_ireq_t", 32'(s_ireq), 32'h0);
    step(1, 0, 0, 1, '0);
    chk("redir_occ_t1",   32'(s_occ),   32'h0);
    chk("redir_ireq_t1",  32'(s_ireq),  32'h1);
    chk("redir_iaddr_t1", 32'(s_iaddr), 32'h200);
    step(1, 0, 0, 1, '0);
    chk("redir_valid_t2", 32'(s_valid), 32'h0);
    step(1, 0, 0, 1, '0);
    chk("redir_valid_t3", 32'(s_valid), 32'h1);
    chk("redir_oaddr_t3", 32'(s_oaddr), 32'h200);

    // Redirect coinciding with a pop handshake.
    step(1, 1, 0, 1, 30'h300);
    chk("rpop_valid", 32'(s_valid), 32'h1);
    step(1, 0, 0, 1, '0);
    chk("rpop_occ", 32'(s_occ), 32'h0);

    // HALT during streaming.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, '0);
    resume = s_iaddr + AW'(1);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, 1, '0);
      chk("halt_ireq",  32'(s_ireq),  32'h0);
      chk("halt_iaddr", 32'(s_iaddr), 32'(resume));
    end
    step(1, 0, 0, 1, '0);
    chk("halt_resume_ireq",  32'(s_ireq),  32'h1);
    chk("halt_resume_iaddr", 32'(s_iaddr), 32'(resume));

    // Address wrap.
    step(1, 1, 0, 1, 30'h3FFF_FFFE);
    n = 0;
    for (int i = 0; i < 12 && n < 4; i++) begin
      step(1, 0, 0, 1, '0);
      if (s_valid) begin got[n] = s_oaddr; n++; end
    end
    if (n < 4) begin
      failures++; $display("FAIL wrap_collect: got %0d words expected 4", n);
    end
    for (int i = 0; i < n; i++) chk("wrap_oaddr", 32'(got[i]), 32'(wrap_exp[i]));

    // Mid-run reset with two entries queued.
    ok = 1'b0;
    for (int i = 0; i < 6 && !ok; i++) begin
      if (mq.size() == 2) ok = 1'b1;
      else step(1, 0, 0, 0, '0);
    end
    if (!ok) begin
      failures++; $display("FAIL rst_setup: timeout reaching occ=2");
    end
    step(0, 0, 0, 1, '0);
    chk("rst_ireq",   32'(s_ireq),   32'h0);
    chk("rst_iaddr",  32'(s_iaddr),  32'(RA));
    chk("rst_valid",  32'(s_valid),  32'h0);
    chk("rst_oinstr", s_oinstr,      32'h0);
    chk("rst_occ",    32'(s_occ),    32'h0);
    step(1, 0, 0, 1, '0);
    chk("rst_rel_ireq",  32'(s_ireq),  32'h1);
    chk("rst_rel_iaddr", 32'(s_iaddr), 32'(RA));
    step(1, 0, 0, 1, '0);
    step(1, 0, 0, 1, '0);
    chk("rst_first_valid", 32'(s_valid), 32'h1);
    chk("rst_first_oaddr", 32'(s_oaddr), 32'(RA));

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) > 1,
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 70,
           AW'($urandom()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
